// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: data width, divide-sequencer FSM encoding
// and the two's-complement negate helper used by the sign fix-up logic.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        WAIT = 2'd2,
        FIX  = 2'd3
    } div_state_t;

    function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] x);
        return ~x + DATA_W'(1);
    endfunction

endpackage

// File: rtl/div32.sv
// Combinational 32-bit unsigned restoring divider (d / v -> q, r).
// A zero divisor yields q = all ones and r = d.
module div32
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] d_i,
    input  logic [DATA_W-1:0] v_i,
    output logic [DATA_W-1:0] q_o,
    output logic [DATA_W-1:0] r_o
);

    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] quo;

    // One extra remainder bit so the shifted partial remainder never overflows.
    always_comb begin
        rem = '0;
        quo = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            rem = {rem[DATA_W-1:0], d_i[i]};
            if (rem >= {1'b0, v_i}) begin
                rem    = rem - {1'b0, v_i};
                quo[i] = 1'b1;
            end
        end
    end

    assign q_o = quo;
    assign r_o = rem[DATA_W-1:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed/unsigned divide sequencer around div32, writing HI (remainder) / LO (quotient).
// Optional macro DIV_BYZERO_TRAP_EN: divide-by-zero skips the wait window and pulses div0 instead of updating HI/LO.
module div_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned DIV_WAIT_CYCLES = 4
)
(
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
`ifdef DIV_BYZERO_TRAP_EN
    ,
    output logic              div0
`endif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_WAIT_CYCLES - 1);

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              sgn_q, sgn_d;
    logic              dneg_q, dneg_d;
    logic              vneg_q, vneg_d;
    logic [DATA_W-1:0] dmag_q, dmag_d;
    logic [DATA_W-1:0] vmag_q, vmag_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef DIV_BYZERO_TRAP_EN
    logic              zero_q, zero_d;
    logic              div0_q, div0_d;
`endif

    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;

    // Magnitude registers stay stable across the whole WAIT window (multicycle path).
    div32 u_div32 (
        .d_i (dmag_q),
        .v_i (vmag_q),
        .q_o (quo),
        .r_o (rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        dneg_d  = dneg_q;
        vneg_d  = vneg_q;
        dmag_d  = dmag_q;
        vmag_d  = vmag_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = (state_q != IDLE);
        done_d  = 1'b0;
`ifdef DIV_BYZERO_TRAP_EN
        zero_d  = zero_q;
        div0_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    sgn_d   = signed_op;
                    state_d = PREP;
                end
            end
            PREP: begin
                dneg_d  = sgn_q & dvd_q[DATA_W-1];
                vneg_d  = sgn_q & dvs_q[DATA_W-1];
                dmag_d  = dneg_d ? twos_neg(dvd_q) : dvd_q;
                vmag_d  = vneg_d ? twos_neg(dvs_q) : dvs_q;
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
`ifdef DIV_BYZERO_TRAP_EN
                zero_d  = (dvs_q == '0);
                if (zero_d) begin
                    state_d = FIX;
                end
`endif
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef DIV_BYZERO_TRAP_EN
                if (zero_q) begin
                    div0_d = 1'b1;
                end else begin
                    lo_d = (dneg_q ^ vneg_q) ? twos_neg(quo) : quo;
                    hi_d = dneg_q ? twos_neg(rem) : rem;
                end
`else
                // Quotient sign follows the operand signs; remainder follows the dividend.
                lo_d = (dneg_q ^ vneg_q) ? twos_neg(quo) : quo;
                hi_d = dneg_q ? twos_neg(rem) : rem;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
            dneg_q  <= 1'b0;
            vneg_q  <= 1'b0;
            dmag_q  <= '0;
            vmag_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_BYZERO_TRAP_EN
            zero_q  <= 1'b0;
            div0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
            dneg_q  <= dneg_d;
            vneg_q  <= vneg_d;
            dmag_q  <= dmag_d;
            vmag_q  <= vmag_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIV_BYZERO_TRAP_EN
            zero_q  <= zero_d;
            div0_q  <= div0_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;
`ifdef DIV_BYZERO_TRAP_EN
    assign div0   = div0_q;
`endif

endmodule
